// File: rtl/pulse_interval_monitor.sv
// Measures clock cycles between rising edges of a terminal-count pulse, keeping
// last/min/max interval statistics, an event count and a sticky gap timeout alarm.
module pulse_interval_monitor #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned EVT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_in,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] timeout_limit,
  output logic [CNT_WIDTH-1:0] interval,
  output logic                 interval_valid,
  output logic [CNT_WIDTH-1:0] min_interval,
  output logic [CNT_WIDTH-1:0] max_interval,
  output logic [EVT_WIDTH-1:0] pulse_count,
  output logic                 timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 pulse_d_q;
  logic [CNT_WIDTH-1:0] gap_q, gap_d;
  logic [CNT_WIDTH-1:0] interval_q, interval_d;
  logic                 interval_valid_q, interval_valid_d;
  logic [CNT_WIDTH-1:0] min_interval_q, min_interval_d;
  logic [CNT_WIDTH-1:0] max_interval_q, max_interval_d;
  logic [EVT_WIDTH-1:0] pulse_count_q, pulse_count_d;
  logic                 timeout_q, timeout_d;

  logic rise;
  logic gap_at_limit;

  assign rise         = pulse_in & ~pulse_d_q;
  assign gap_at_limit = (timeout_limit != '0) && (gap_q == timeout_limit);

  always_comb begin
    state_d          = state_q;
    gap_d            = gap_q;
    interval_d       = interval_q;
    interval_valid_d = 1'b0;
    min_interval_d   = min_interval_q;
    max_interval_d   = max_interval_q;
    pulse_count_d    = pulse_count_q;
    timeout_d        = timeout_q;

    if (clear) begin
      state_d        = ST_IDLE;
      gap_d          = '0;
      interval_d     = '0;
      min_interval_d = '1;
      max_interval_d = '0;
      pulse_count_d  = '0;
      timeout_d      = 1'b0;
    end else if (!enable) begin
      // Statistics and alarm hold; only the measurement itself is abandoned.
      state_d = ST_IDLE;
      gap_d   = '0;
    end else begin
      if (rise && (pulse_count_q != '1)) begin
        pulse_count_d = pulse_count_q + EVT_WIDTH'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_MEASURE;
            gap_d   = CNT_WIDTH'(1);
          end
        end

        ST_MEASURE: begin
          // A rise landing on the limit cycle wins over the timeout.
          if (rise) begin
            interval_d       = gap_q;
            interval_valid_d = 1'b1;
            gap_d            = CNT_WIDTH'(1);
            if (gap_q < min_interval_q) begin
              min_interval_d = gap_q;
            end
            if (gap_q > max_interval_q) begin
              max_interval_d = gap_q;
            end
          end else if (gap_at_limit) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end else if (gap_q != '1) begin
            gap_d = gap_q + CNT_WIDTH'(1);
          end
        end

        ST_TIMEOUT: begin
          if (rise) begin
            state_d = ST_MEASURE;
            gap_d   = CNT_WIDTH'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_d_q        <= 1'b0;
      state_q          <= ST_IDLE;
      gap_q            <= '0;
      interval_q       <= '0;
      interval_valid_q <= 1'b0;
      min_interval_q   <= '1;
      max_interval_q   <= '0;
      pulse_count_q    <= '0;
      timeout_q        <= 1'b0;
    end else begin
      pulse_d_q        <= pulse_in;
      state_q          <= state_d;
      gap_q            <= gap_d;
      interval_q       <= interval_d;
      interval_valid_q <= interval_valid_d;
      min_interval_q   <= min_interval_d;
      max_interval_q   <= max_interval_d;
      pulse_count_q    <= pulse_count_d;
      timeout_q        <= timeout_d;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = interval_valid_q;
  assign min_interval   = min_interval_q;
  assign max_interval   = max_interval_q;
  assign pulse_count    = pulse_count_q;
  assign timeout        = timeout_q;
  assign busy           = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Directed bench for pulse_interval_monitor with hand-computed expectations.
module tb_pulse_interval_monitor;

  localparam int unsigned CW = 32;
  localparam int unsigned EW = 16;

  logic          clk;
  logic          reset;
  logic          pulse_in;
  logic          enable;
  logic          clear;
  logic [CW-1:0] timeout_limit;
  logic [CW-1:0] interval;
  logic          interval_valid;
  logic [CW-1:0] min_interval;
  logic [CW-1:0] max_interval;
  logic [EW-1:0] pulse_count;
  logic          timeout;
  logic          busy;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic        saw_valid;

  pulse_interval_monitor #(.CNT_WIDTH(CW), .EVT_WIDTH(EW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pulse_in       (pulse_in),
    .enable         (enable),
    .clear          (clear),
    .timeout_limit  (timeout_limit),
    .interval       (interval),
    .interval_valid (interval_valid),
    .min_interval   (min_interval),
    .max_interval   (max_interval),
    .pulse_count    (pulse_count),
    .timeout        (timeout),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive pulse_in, advance one clock, settle just after the edge.
  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    pulse_in      = 1'b0;
    enable        = 1'b1;
    clear         = 1'b0;
    timeout_limit = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_interval", 64'(interval), 64'h0);
    check("rst_valid", 64'(interval_valid), 64'h0);
    check("rst_min", 64'(min_interval), 64'hFFFF_FFFF);
    check("rst_max", 64'(max_interval), 64'h0);
    check("rst_count", 64'(pulse_count), 64'h0);
    check("rst_timeout", 64'(timeout), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    #3 reset = 1'b0;

    // Counter period 751: one-cycle pulse every 751 cycles.
    step(1'b1);
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_no_valid_first", 64'(interval_valid), 64'h0);
    repeat (750) step(1'b0);
    step(1'b1);
    check("t1_valid", 64'(interval_valid), 64'h1);
    check("t1_interval", 64'(interval), 64'd751);
    check("t1_min", 64'(min_interval), 64'd751);
    check("t1_max", 64'(max_interval), 64'd751);
    step(1'b0);
    check("t1_valid_one_cycle", 64'(interval_valid), 64'h0);
    repeat (749) step(1'b0);
    step(1'b1);
    check("t1_count3", 64'(pulse_count), 64'd3);

    // Level held high counts once.
    do_clear();
    check("clr_count", 64'(pulse_count), 64'h0);
    check("clr_min", 64'(min_interval), 64'hFFFF_FFFF);
    check("clr_busy", 64'(busy), 64'h0);
    saw_valid = 1'b0;
    repeat (20) begin
      step(1'b1);
      if (interval_valid) saw_valid = 1'b1;
    end
    repeat (5) begin
      step(1'b0);
      if (interval_valid) saw_valid = 1'b1;
    end
    check("t2_count", 64'(pulse_count), 64'd1);
    check("t2_no_valid", 64'(saw_valid), 64'h0);

    // Edges at relative cycles 10, 110, 160, 460.
    do_clear();
    for (int c = 0; c <= 470; c++) begin
      step((c == 10) || (c == 110) || (c == 160) || (c == 460));
      if (c == 110) begin
        check("t3_valid_a", 64'(interval_valid), 64'h1);
        check("t3_int_a", 64'(interval), 64'd100);
      end
      if (c == 160) check("t3_int_b", 64'(interval), 64'd50);
      if (c == 460) check("t3_int_c", 64'(interval), 64'd300);
    end
    check("t3_min", 64'(min_interval), 64'd50);
    check("t3_max", 64'(max_interval), 64'd300);
    check("t3_count", 64'(pulse_count), 64'd4);

    // Timeout at limit 200.
    do_clear();
    timeout_limit = 32'd200;
    step(1'b1);
    repeat (199) step(1'b0);
    check("t4_pre_timeout", 64'(timeout), 64'h0);
    check("t4_pre_busy", 64'(busy), 64'h1);
    step(1'b0);
    check("t4_timeout", 64'(timeout), 64'h1);
    check("t4_busy_off", 64'(busy), 64'h0);
    repeat (30) step(1'b0);
    step(1'b1);
    check("t4_rearm_busy", 64'(busy), 64'h1);
    check("t4_rearm_novalid", 64'(interval_valid), 64'h0);
    check("t4_sticky", 64'(timeout), 64'h1);
    check("t4_count", 64'(pulse_count), 64'd2);
    do_clear();
    check("t4_clr_timeout", 64'(timeout), 64'h0);
    check("t4_clr_min", 64'(min_interval), 64'hFFFF_FFFF);

    // Rise exactly at the limit wins.
    timeout_limit = 32'd100;
    step(1'b1);
    for (int r = 0; r < 3; r++) begin
      repeat (99) step(1'b0);
      step(1'b1);
      check("t5_valid", 64'(interval_valid), 64'h1);
      check("t5_interval", 64'(interval), 64'd100);
      check("t5_no_timeout", 64'(timeout), 64'h0);
    end

    // Asynchronous reset between clock edges.
    repeat (3) step(1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_count", 64'(pulse_count), 64'h0);
    check("t6_interval", 64'(interval), 64'h0);
    check("t6_min", 64'(min_interval), 64'hFFFF_FFFF);
    check("t6_max", 64'(max_interval), 64'h0);
    #2 reset = 1'b0;
    timeout_limit = '0;

    // enable=0 ignores edges and returns to idle.
    step(1'b1);
    check("t7_busy_on", 64'(busy), 64'h1);
    repeat (10) step(1'b0);
    enable = 1'b0;
    step(1'b0);
    check("t7_busy_off", 64'(busy), 64'h0);
    repeat (5) begin
      step(1'b1);
      step(1'b0);
    end
    check("t7_count_held", 64'(pulse_count), 64'd1);
    check("t7_idle", 64'(busy), 64'h0);
    enable = 1'b1;
    step(1'b0);
    step(1'b1);
    check("t7_restart_busy", 64'(busy), 64'h1);
    check("t7_restart_novalid", 64'(interval_valid), 64'h0);
    check("t7_restart_count", 64'(pulse_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
